exec_sequencer: RTL

//  Multi-cycle control sequencer for the 32-bit processor datapath.

---
 rtl/exec_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, gates register-file and data-memory write
// enables, runs the data-memory request/ready handshake with a timeout,
// and provides run/step/halt debug control plus a retired-instruction count.
//
// Data-memory handshake: mem_req is high in every MEM cycle; the access
// completes in the cycle where mem_ready is sampled high alongside mem_req.
// If mem_ready never arrives within MEM_TIMEOUT MEM cycles the sequencer
// parks in FAULT. mem_ready arriving in the limit cycle still completes.
module exec_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             clear,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    input  logic             rf_we,
    input  logic             mem_ready,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             we1_en,
    output logic             we2_en,
    output logic             mem_req,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          state;
    state_t          state_nx;
    logic            step_mode;
    logic            step_mode_nx;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nx;
    logic [TO_W-1:0] to_inc;

    assign to_inc = to_cnt + TO_W'(1);

    // State, step-mode flag and MEM wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            step_mode <= 1'b0;
            to_cnt    <= '0;
        end else begin
            state     <= state_nx;
            step_mode <= step_mode_nx;
            to_cnt    <= to_cnt_nx;
        end
    end

    // Retired-instruction counter: one increment per WB cycle, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count <= '0;
        end else if (state == S_WB) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Next-state logic; run/halt_req are only consulted at instruction boundaries.
    always_comb begin
        state_nx     = state;
        step_mode_nx = step_mode;
        to_cnt_nx    = to_cnt;
        case (state)
            S_IDLE: begin
                if (step) begin
                    state_nx     = S_FETCH;
                    step_mode_nx = 1'b1;
                end else if (run && !halt_req) begin
                    state_nx     = S_FETCH;
                    step_mode_nx = 1'b0;
                end
            end
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = is_halt ? S_HALTED : S_EXEC;
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_nx  = S_MEM;
                    to_cnt_nx = '0;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_nx = S_WB;
                end else begin
                    to_cnt_nx = to_inc;
                    if (to_inc == TO_LIMIT) begin
                        state_nx = S_FAULT;
                    end
                end
            end
            S_WB: begin
                if (step_mode || halt_req || !run) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            S_HALTED, S_FAULT: begin
                if (clear) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode from the registered state; only the write enables see inputs.
    always_comb begin
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        we1_en  = 1'b0;
        we2_en  = 1'b0;
        mem_req = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;
        fault   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_load = 1'b1;
                busy    = 1'b1;
            end
            S_DECODE, S_EXEC: busy = 1'b1;
            S_MEM: begin
                mem_req = 1'b1;
                we2_en  = is_store;
                busy    = 1'b1;
            end
            S_WB: begin
                pc_inc = 1'b1;
                we1_en = rf_we;
                busy   = 1'b1;
            end
            S_HALTED: halted = 1'b1;
            S_FAULT:  fault  = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule
